// File: rtl/audio_pkg.sv
// audio_pkg: shared constants, widths and FIFO entry type for the audio
// sample path.
package audio_pkg;

  localparam int DEFAULT_DATA_SIZE = 24;
  localparam int DEFAULT_CW        = 1;

  typedef struct packed {
    logic [DEFAULT_CW-1:0]        chan;
    logic [DEFAULT_DATA_SIZE-1:0] data;
  } fifo_entry_t;

  function automatic int acc_width(input int data_size,
                                   input int log2_factor);
    return data_size + log2_factor;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO, power-of-two depth.
// The head entry is visible on rdata whenever empty is low.
module sync_fifo
  import audio_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_pop;
  logic             do_push;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A full FIFO still takes a write when the head leaves on the same edge.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/sample_decimator.sv
// sample_decimator: per-channel decimate-by-2**LOG2_FACTOR with output FIFO.
// Define SAMPLE_DECIMATOR_AVERAGE_EN for floored group mean instead of pick.
module sample_decimator
  import audio_pkg::*;
#(
  parameter int DATA_SIZE   = DEFAULT_DATA_SIZE,
  parameter int CHANNELS    = 2,
  parameter int LOG2_FACTOR = 2,
  parameter int OUT_DEPTH   = 4,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic [CW-1:0]        in_chan,
  input  logic [DATA_SIZE-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CW-1:0]        out_chan,
  output logic [DATA_SIZE-1:0] out_data,
  output logic                 overrun
);

  localparam int FACTOR = 1 << LOG2_FACTOR;
  localparam int CNTW   = (LOG2_FACTOR > 0) ? LOG2_FACTOR : 1;
  localparam int AW     = acc_width(DATA_SIZE, LOG2_FACTOR);

  typedef struct packed {
    logic [CW-1:0]        chan;
    logic [DATA_SIZE-1:0] data;
  } entry_t;

  logic [CNTW-1:0]      cnt [CHANNELS];
  logic                 chan_ok;
  logic [CW-1:0]        idx;
  logic                 accept;
  logic                 last;
  logic                 push;
  logic                 pop;
  logic                 full;
  logic                 empty;
  logic [DATA_SIZE-1:0] result;
  entry_t               wr_entry;
  entry_t               head;

  assign chan_ok = {1'b0, in_chan} < (CW+1)'(CHANNELS);
  assign idx     = chan_ok ? in_chan : '0;
  assign accept  = in_valid & chan_ok & ~flush;
  assign last    = (cnt[idx] == CNTW'(FACTOR - 1));
  assign push    = accept & last;
  assign pop     = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) cnt[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < CHANNELS; i++) cnt[i] <= '0;
    end else if (accept) begin
      cnt[idx] <= last ? '0 : cnt[idx] + 1'b1;
    end
  end

`ifdef SAMPLE_DECIMATOR_AVERAGE_EN
  logic signed [AW-1:0] acc [CHANNELS];
  logic signed [AW-1:0] sum;

  assign sum    = acc[idx] + AW'($signed(in_data));
  assign result = DATA_SIZE'(sum >>> LOG2_FACTOR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) acc[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < CHANNELS; i++) acc[i] <= '0;
    end else if (accept) begin
      acc[idx] <= last ? '0 : sum;
    end
  end
`else
  assign result = in_data;
`endif

  // Dropped results still clear channel state above; only the flag records it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (flush) begin
      overrun <= 1'b0;
    end else if (push && full && !pop) begin
      overrun <= 1'b1;
    end
  end

  assign wr_entry = '{chan: idx, data: result};

  sync_fifo #(
    .WIDTH($bits(entry_t)),
    .DEPTH(OUT_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .flush(flush),
    .push (push),
    .wdata(wr_entry),
    .pop  (pop),
    .rdata(head),
    .full (full),
    .empty(empty)
  );

  assign out_valid = ~empty;
  assign out_chan  = empty ? '0 : head.chan;
  assign out_data  = empty ? '0 : head.data;

endmodule
